// File: rtl/lcd_read_ctrl.sv
// lcd_read_ctrl: HD44780-style LCD read cycles (BF/AC or data RAM) with optional busy-flag polling.
// Define LCD_READ_AC_EN to add the lcd_bf/lcd_ac outputs holding the last BF/AC read.
module lcd_read_ctrl #(
  parameter int T_AS     = 2,
  parameter int T_EH     = 10,
  parameter int T_EL     = 10,
  parameter int POLL_MAX = 1023
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req,
  input  logic       req_rs,
  input  logic       poll,
  output logic       busy,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       timeout,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_data_oe,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
`ifdef LCD_READ_AC_EN
  ,
  output logic       lcd_bf,
  output logic [6:0] lcd_ac
`endif
);
  typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, E_LOW, DONE} state_t;
  state_t state, nxt;
  logic [7:0]  cnt;
  logic [15:0] pcnt;
  logic        rs_q, poll_q, tdone, bf_poll, again, active, rs_n;
  always_comb begin
    tdone   = cnt == (state == SETUP ? 8'(T_AS - 1) : state == E_HIGH ? 8'(T_EH - 1) : 8'(T_EL - 1));
    bf_poll = poll_q && !rs_q && rd_data[7];
    again   = bf_poll && pcnt < 16'(POLL_MAX);
    nxt     = state;
    case (state)
      IDLE:    nxt = req ? SETUP : IDLE;
      SETUP:   nxt = tdone ? E_HIGH : SETUP;
      E_HIGH:  nxt = tdone ? E_LOW : E_HIGH;
      E_LOW:   nxt = tdone ? (again ? SETUP : DONE) : E_LOW;
      default: nxt = IDLE;
    endcase
    active = nxt == SETUP || nxt == E_HIGH || nxt == E_LOW;
    rs_n   = state == IDLE ? req_rs : rs_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      pcnt        <= '0;
      rs_q        <= 1'b0;
      poll_q      <= 1'b0;
      busy        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= 8'h00;
      timeout     <= 1'b0;
      lcd_data_oe <= 1'b1;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_rw      <= 1'b0;
`ifdef LCD_READ_AC_EN
      lcd_bf      <= 1'b0;
      lcd_ac      <= 7'h00;
`endif
    end else begin
      state <= nxt;
      cnt   <= (nxt != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
      if (state == IDLE && req) begin
        rs_q    <= req_rs;
        poll_q  <= poll;
        pcnt    <= '0;
        timeout <= 1'b0;
      end
      if (state == E_HIGH && tdone) begin
        rd_data <= lcd_data_in;
        pcnt    <= pcnt + 16'd1;
`ifdef LCD_READ_AC_EN
        if (!rs_q) begin
          lcd_bf <= lcd_data_in[7];
          lcd_ac <= lcd_data_in[6:0];
        end
`endif
      end
      // a poll that leaves E_LOW with BF still set has exhausted its read budget
      if (state == E_LOW && tdone && bf_poll && !again) timeout <= 1'b1;
      busy        <= nxt != IDLE;
      rd_valid    <= nxt == DONE;
      lcd_e       <= nxt == E_HIGH;
      lcd_rw      <= active;
      lcd_rs      <= active && rs_n;
      lcd_data_oe <= !active;
    end
  end
endmodule

// File: tb/tb_lcd_read_ctrl.sv
// tb_lcd_read_ctrl: directed and randomized read/poll transactions checked against a transaction-level model.
module tb_lcd_read_ctrl;
  localparam int T_AS = 2, T_EH = 10, T_EL = 10, PMAX = 4, CYC = T_AS + T_EH + T_EL;
  logic clk = 1'b0, resetn = 1'b0, req = 1'b0, req_rs = 1'b0, poll = 1'b0;
  logic busy, rd_valid, timeout, lcd_data_oe, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] rd_data, lcd_data_in;
`ifdef LCD_READ_AC_EN
  logic lcd_bf;
  logic [6:0] lcd_ac;
  logic [7:0] exp_acreg = 8'h00;
`endif
  int tests = 0, fails = 0, e_pulses = 0, rv_pulses = 0;
  logic [7:0] data_q[$];
  logic [7:0] src[$];
  always #5 clk = ~clk;
  lcd_read_ctrl #(.T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL), .POLL_MAX(PMAX)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_rs(req_rs), .poll(poll),
    .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data), .timeout(timeout),
    .lcd_data_in(lcd_data_in), .lcd_data_oe(lcd_data_oe), .lcd_e(lcd_e),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
`ifdef LCD_READ_AC_EN
    , .lcd_bf(lcd_bf), .lcd_ac(lcd_ac)
`endif
  );
  // the LCD presents the next queued byte on each E rising edge
  always @(posedge lcd_e) begin
    e_pulses++;
    if (data_q.size() > 0) lcd_data_in = data_q.pop_front();
  end
  always @(negedge clk) if (rd_valid) rv_pulses++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_read(input logic rs, input logic pl);
    int k, c, e_first, e_hi;
    logic to;
    logic [7:0] fin;
    k = 1;
    if (pl && !rs) while (k < PMAX && src[k-1][7]) k++;
    fin = src[k-1];
    to = pl && !rs && fin[7];
    data_q = src;
    e_pulses = 0;
    rv_pulses = 0;
    @(negedge clk);
    req = 1'b1; req_rs = rs; poll = pl;
    @(posedge clk);
    #1;
    req = 1'b0; req_rs = 1'($urandom); poll = 1'($urandom);
    c = 1; e_first = 0; e_hi = 0;
    check("setup_rw", 32'(lcd_rw), 32'd1);
    check("setup_rs", 32'(lcd_rs), 32'(rs));
    check("setup_oe", 32'(lcd_data_oe), 32'd0);
    check("busy", 32'(busy), 32'd1);
    check("timeout_clr", 32'(timeout), 32'd0);
    while (!rd_valid && c < 2000) begin
      if (lcd_e) begin
        e_hi++;
        if (e_first == 0) e_first = c;
      end
      @(posedge clk);
      #1 c++;
    end
    check("latency", 32'(c), 32'(k * CYC + 1));
    check("e_first", 32'(e_first), 32'(T_AS + 1));
    check("e_high_cycles", 32'(e_hi), 32'(k * T_EH));
    check("e_pulses", 32'(e_pulses), 32'(k));
    check("rd_data", 32'(rd_data), 32'(fin));
    check("timeout", 32'(timeout), 32'(to));
    check("done_pins", 32'({lcd_rw, lcd_rs, lcd_data_oe, lcd_e, busy}), 32'b00101);
`ifdef LCD_READ_AC_EN
    if (!rs) exp_acreg = fin;
    check("lcd_bf", 32'(lcd_bf), 32'(exp_acreg[7]));
    check("lcd_ac", 32'(lcd_ac), 32'(exp_acreg[6:0]));
`endif
    @(posedge clk);
    #1;
    check("valid_pulses", 32'(rv_pulses), 32'd1);
    check("idle_busy", 32'({busy, rd_valid}), 32'd0);
    check("timeout_hold", 32'(timeout), 32'(to));
  endtask
  initial begin
    int w;
    repeat (3) @(negedge clk);
    check("rst_pins", 32'({lcd_e, lcd_rs, lcd_rw, lcd_data_oe, busy, rd_valid, timeout}), 32'b0001000);
    check("rst_data", 32'(rd_data), 32'h00);
    resetn = 1'b1;
    rv_pulses = 0;
    repeat (10) @(negedge clk);
    check("idle_pins", 32'({lcd_e, lcd_rw, lcd_data_oe, busy}), 32'b0010);
    check("idle_no_valid", 32'(rv_pulses), 32'd0);
    src = {8'h41, 8'h00, 8'h00, 8'h00};
    run_read(1'b1, 1'b0);
    src = {8'h85, 8'h85, 8'h05, 8'h05, 8'h05};
    run_read(1'b0, 1'b1);
    src = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    run_read(1'b0, 1'b1);
    src = {8'hC1, 8'h85, 8'h85, 8'h85};
    run_read(1'b1, 1'b1);
    src = {8'h23, 8'h00, 8'h00, 8'h00};
    run_read(1'b0, 1'b0);
    src = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_read(1'b1, 1'b0);
    // reset in the middle of the E high phase
    data_q = {8'h5A};
    rv_pulses = 0;
    @(negedge clk);
    req = 1'b1; req_rs = 1'b1; poll = 1'b0;
    @(posedge clk);
    #1 req = 1'b0;
    w = 0;
    while (!lcd_e && w < 50) begin
      @(posedge clk);
      #1 w++;
    end
    check("rst_e_seen", 32'(lcd_e), 32'd1);
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("arst_pins", 32'({lcd_e, lcd_rw, lcd_rs, busy, lcd_data_oe, rd_valid}), 32'b000010);
    repeat (30) @(negedge clk);
    check("arst_no_valid", 32'(rv_pulses), 32'd0);
    resetn = 1'b1;
    src = {8'h37, 8'h00, 8'h00, 8'h00};
    run_read(1'b1, 1'b0);
    for (int i = 0; i < 25; i++) begin
      src.delete();
      for (int j = 0; j < 6; j++) src.push_back({1'($urandom_range(3) != 0), 7'($urandom)});
      run_read(1'($urandom), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
